conv_acc: RTL

Consumer end of the nested-loop address stream. Takes one weight/input address pair per cycle from the loop generator and reads both operand memories. Multiplies the operands and accumulates the products. On the element flagged `last` it emits one accumulated result. It sits between the `loop1` address generator and the result write-back, and replaces the SystemC reference model as the consumer of `wa`/`ia`.

---
 rtl/conv_pkg.sv | 46 ++++
 rtl/conv_acc_sat_acc.sv | 89 ++++++++
 rtl/conv_acc.sv | 110 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_acc multiply-accumulate consumer.
// Holds default widths, the per-stage flag bundle and the saturating adder.
package conv_pkg;

    localparam int DW_DEF   = 8;
    localparam int MAW_DEF  = 10;
    localparam int ACCW_DEF = 24;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 64;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_flags_t;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Operands must already fit in w bits (sign-extended to SAT_W); the sum is
    // clamped to the signed w-bit range and ovf reports whether a clamp happened.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                         input logic signed [SAT_W-1:0] b,
                                         input int                      w);
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        s     = a + b;
        hi    = $signed((64'd1 << (w - 1)) - 64'd1);
        lo    = -hi - 64'sd1;
        r.sum = s;
        r.ovf = 1'b0;
        if (s > hi) begin
            r.sum = hi;
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.sum = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_acc_sat_acc.sv
// S4 of conv_acc: saturating accumulator with element count, per-stream sat
// flag and the held result register that is pulsed out on the last element.
module conv_sat_acc
    import conv_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stage_flags_t           in_flags,
    input  logic signed [2*DW-1:0] prod,
    output logic                   stage_busy,
    output logic                   out_valid,
    output logic signed [ACCW-1:0] out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   sat_err
);

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   busy_q, busy_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [ACCW-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]       out_count_q, out_count_d;
    logic                   sat_err_q, sat_err_d;
    sat_res_t               sum_r;

    // A first element restarts the stream, discarding whatever was left over;
    // the result register is loaded with the post-update value on last.
    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        busy_d      = in_flags.valid;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        sat_err_d   = sat_err_q;
        sum_r       = sat_add(64'(acc_q), 64'(prod), ACCW);
        if (in_flags.valid) begin
            if (in_flags.first) begin
                acc_d   = ACCW'(prod);
                count_d = CNT_W'(1);
                sat_d   = 1'b0;
            end else begin
                acc_d   = ACCW'(sum_r.sum);
                count_d = count_q + CNT_W'(1);
                sat_d   = sat_q | sum_r.ovf;
            end
            if (in_flags.last) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_d;
                out_count_d = count_d;
                sat_err_d   = sat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            sat_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            sat_err_q   <= sat_err_d;
        end
    end

    assign stage_busy = busy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign sat_err    = sat_err_q;

endmodule

// File: rtl/conv_acc.sv
// Consumer of the loop1 address stream: reads weight/input operands, multiplies
// them and hands the products to the saturating accumulator (S1-S3 live here).
module conv_acc
    import conv_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int MAW  = MAW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [31:0]            wa,
    input  logic [31:0]            ia,
    output logic                   w_re,
    output logic [MAW-1:0]         w_addr,
    input  logic signed [DW-1:0]   w_data,
    output logic                   i_re,
    output logic [MAW-1:0]         i_addr,
    input  logic signed [DW-1:0]   i_data,
    output logic                   out_valid,
    output logic signed [ACCW-1:0] out_data,
    output logic [15:0]            out_count,
    output logic                   sat_err,
    output logic                   addr_err,
    output logic                   busy
);

    stage_flags_t           s1_flags_q, s1_flags_d;
    stage_flags_t           s2_flags_q, s2_flags_d;
    stage_flags_t           s3_flags_q, s3_flags_d;
    logic                   first_armed_q, first_armed_d;
    logic [MAW-1:0]         w_addr_q, w_addr_d;
    logic [MAW-1:0]         i_addr_q, i_addr_d;
    logic                   addr_err_q, addr_err_d;
    logic signed [2*DW-1:0] prod_q, prod_d;
    logic                   acc_busy;
    logic                   addr_high;

    assign addr_high = ((wa >> MAW) != 32'd0) || ((ia >> MAW) != 32'd0);

    // S1 tags the element; first is armed again by every accepted last so a
    // new stream may follow with no bubble.
    always_comb begin
        s1_flags_d.valid = in_valid;
        s1_flags_d.first = in_valid & first_armed_q;
        s1_flags_d.last  = in_valid & in_last;
        first_armed_d    = in_valid ? in_last : first_armed_q;
        w_addr_d         = in_valid ? wa[MAW-1:0] : w_addr_q;
        i_addr_d         = in_valid ? ia[MAW-1:0] : i_addr_q;
        addr_err_d       = addr_err_q | (in_valid & addr_high);
    end

    // Read data arrives while the element sits in S2, so it is multiplied
    // straight from the memory outputs and only the product is registered.
    always_comb begin
        s2_flags_d = s1_flags_q;
        s3_flags_d = s2_flags_q;
        prod_d     = prod_q;
        if (s2_flags_q.valid) begin
            prod_d = (2*DW)'(w_data) * (2*DW)'(i_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_flags_q    <= '0;
            s2_flags_q    <= '0;
            s3_flags_q    <= '0;
            first_armed_q <= 1'b1;
            w_addr_q      <= '0;
            i_addr_q      <= '0;
            addr_err_q    <= 1'b0;
            prod_q        <= '0;
        end else begin
            s1_flags_q    <= s1_flags_d;
            s2_flags_q    <= s2_flags_d;
            s3_flags_q    <= s3_flags_d;
            first_armed_q <= first_armed_d;
            w_addr_q      <= w_addr_d;
            i_addr_q      <= i_addr_d;
            addr_err_q    <= addr_err_d;
            prod_q        <= prod_d;
        end
    end

    conv_sat_acc #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_sat_acc (
        .clk        (clk),
        .rst        (rst),
        .in_flags   (s3_flags_q),
        .prod       (prod_q),
        .stage_busy (acc_busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .sat_err    (sat_err)
    );

    assign w_re     = s1_flags_q.valid;
    assign i_re     = s1_flags_q.valid;
    assign w_addr   = w_addr_q;
    assign i_addr   = i_addr_q;
    assign addr_err = addr_err_q;
    assign busy     = s1_flags_q.valid | s2_flags_q.valid | s3_flags_q.valid | acc_busy;

endmodule
